// File: rtl/decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_ctrl_stage
// Purpose  : Registered instruction decode/control stage with a valid/ready
//            output register, load-use stall and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module decode_ctrl_stage #(
    parameter int REG_AW     = 5,
    parameter int SHAMT_W    = 5,
    parameter int ALUOP_W    = 4,
    parameter int LOAD_STALL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_optype,
    output logic [2:0]         out_deref,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [1:0]         out_pccfg,
    output logic               out_ramwe,
    output logic               out_regwe,
    output logic [1:0]         out_regsrc,
    output logic [REG_AW-1:0]  out_rs,
    output logic [REG_AW-1:0]  out_rt,
    output logic [REG_AW-1:0]  out_dst,
    output logic               out_illegal,
    output logic               hazard_stall
);

    localparam logic [1:0] OPT_R     = 2'd0;
    localparam logic [1:0] OPT_I     = 2'd1;
    localparam logic [1:0] OPT_J     = 2'd2;
    localparam logic [2:0] DR_DEST   = 3'b100;
    localparam logic [2:0] DR_OPA    = 3'b010;
    localparam logic [2:0] DR_OPB    = 3'b001;
    localparam logic [1:0] PC_NORMAL = 2'd0;
    localparam logic [1:0] PC_STEP   = 2'd1;
    localparam logic [1:0] PC_REF    = 2'd2;
    localparam logic [1:0] SRC_ALU   = 2'd0;
    localparam logic [1:0] SRC_LOAD  = 2'd1;
    localparam logic [1:0] SRC_PC    = 2'd2;
    localparam logic [2:0] LD_RELOAD = 3'(LOAD_STALL);

    typedef struct packed {
        logic [1:0]         optype;
        logic [2:0]         deref;
        logic [ALUOP_W-1:0] aluop;
        logic [SHAMT_W-1:0] shamt;
        logic [1:0]         pccfg;
        logic               ramwe;
        logic               regwe;
        logic [1:0]         regsrc;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  dst;
        logic               illegal;
        logic               is_load;
    } bundle_t;

    logic [5:0]         opcode;
    logic [5:0]         func;
    logic [REG_AW-1:0]  f_rs;
    logic [REG_AW-1:0]  f_rt;
    logic [REG_AW-1:0]  f_rd;
    logic [SHAMT_W-1:0] f_shamt;

    assign opcode  = in_instr[31:26];
    assign func    = in_instr[5:0];
    assign f_rs    = REG_AW'(in_instr[25:21]);
    assign f_rt    = REG_AW'(in_instr[20:16]);
    assign f_rd    = REG_AW'(in_instr[15:11]);
    assign f_shamt = SHAMT_W'(in_instr[10:6]);

    bundle_t dec;

    always_comb begin
        dec         = '0;
        dec.optype  = OPT_R;
        dec.pccfg   = PC_NORMAL;
        dec.regsrc  = SRC_ALU;
        if (opcode == 6'h00) begin
            if (func <= 6'h11) begin
                dec.rs    = f_rs;
                dec.shamt = f_shamt;
            end
            if (func <= 6'h0F) begin
                dec.aluop = ALUOP_W'(func[3:0]);
                dec.deref = DR_OPA | DR_OPB;
                dec.regwe = 1'b1;
                dec.rt    = f_rt;
                dec.dst   = f_rd;
            end else if (func == 6'h10) begin
                dec.deref = DR_OPA;
                dec.pccfg = PC_REF;
            end else if (func == 6'h11) begin
                dec.deref  = DR_OPA;
                dec.pccfg  = PC_REF;
                dec.regwe  = 1'b1;
                dec.regsrc = SRC_PC;
                dec.dst    = f_rd;
            end else begin
                dec.illegal = 1'b1;
            end
        end else if (opcode <= 6'h0F) begin
            dec.optype = OPT_I;
            dec.aluop  = ALUOP_W'(opcode[3:0]);
            dec.deref  = DR_OPA;
            dec.regwe  = 1'b1;
            dec.rs     = f_rs;
            dec.dst    = f_rt;
        end else if (opcode <= 6'h13) begin
            // Branch compare ops occupy the top four ALU codes 0xC..0xF.
            dec.optype = OPT_I;
            dec.aluop  = ALUOP_W'({2'b11, opcode[1:0]});
            dec.deref  = DR_DEST | DR_OPA;
            dec.pccfg  = PC_STEP;
            dec.rs     = f_rs;
            dec.rt     = f_rt;
        end else begin
            case (opcode)
                6'h20: begin
                    dec.optype  = OPT_I;
                    dec.deref   = DR_OPA;
                    dec.regwe   = 1'b1;
                    dec.regsrc  = SRC_LOAD;
                    dec.rs      = f_rs;
                    dec.dst     = f_rt;
                    dec.is_load = 1'b1;
                end
                6'h21: begin
                    dec.optype = OPT_I;
                    dec.deref  = DR_OPA;
                    dec.ramwe  = 1'b1;
                    dec.rs     = f_rs;
                    dec.rt     = f_rt;
                end
                6'h30: begin
                    dec.optype = OPT_J;
                    dec.pccfg  = PC_REF;
                end
                6'h31: begin
                    dec.optype = OPT_J;
                    dec.pccfg  = PC_REF;
                    dec.regwe  = 1'b1;
                    dec.regsrc = SRC_PC;
                    dec.dst    = '1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    logic              valid_q, valid_d;
    bundle_t           bundle_q, bundle_d;
    logic [2:0]        ld_cnt_q, ld_cnt_d;
    logic [REG_AW-1:0] ld_dst_q, ld_dst_d;

    logic held_ld;
    logic cnt_live;
    logic rs_haz;
    logic rt_haz;
    logic hazard;
    logic accept;
    logic out_xfer;

    // Unused sources are decoded as 0, so a zero check also covers "not used".
    assign held_ld  = valid_q & bundle_q.is_load;
    assign cnt_live = (ld_cnt_q != 3'd0);
    assign rs_haz   = (dec.rs != '0) &&
                      ((held_ld && (dec.rs == bundle_q.dst)) || (cnt_live && (dec.rs == ld_dst_q)));
    assign rt_haz   = (dec.rt != '0) &&
                      ((held_ld && (dec.rt == bundle_q.dst)) || (cnt_live && (dec.rt == ld_dst_q)));
    assign hazard   = rs_haz | rt_haz;

    assign in_ready     = ~flush & ~hazard & (~valid_q | out_ready);
    assign hazard_stall = hazard & in_valid & ~flush;
    assign accept       = in_valid & in_ready;
    assign out_xfer     = valid_q & out_ready;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        ld_cnt_d = ld_cnt_q;
        ld_dst_d = ld_dst_q;
        if (out_xfer && bundle_q.is_load) begin
            ld_cnt_d = LD_RELOAD;
            ld_dst_d = bundle_q.dst;
        end else if (cnt_live) begin
            ld_cnt_d = ld_cnt_q - 3'd1;
        end
        if (flush) begin
            valid_d  = 1'b0;
            ld_cnt_d = 3'd0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            ld_cnt_q <= 3'd0;
            ld_dst_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            ld_cnt_q <= ld_cnt_d;
            ld_dst_q <= ld_dst_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_optype  = bundle_q.optype;
    assign out_deref   = bundle_q.deref;
    assign out_aluop   = bundle_q.aluop;
    assign out_shamt   = bundle_q.shamt;
    assign out_pccfg   = bundle_q.pccfg;
    assign out_ramwe   = bundle_q.ramwe;
    assign out_regwe   = bundle_q.regwe;
    assign out_regsrc  = bundle_q.regsrc;
    assign out_rs      = bundle_q.rs;
    assign out_rt      = bundle_q.rt;
    assign out_dst     = bundle_q.dst;
    assign out_illegal = bundle_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_ctrl_stage
// Purpose  : Directed and randomized bench for decode_ctrl_stage with a
//            cycle-indexed reference model of decode, handshake and hazards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_stage;

    localparam int REG_AW     = 5;
    localparam int SHAMT_W    = 5;
    localparam int ALUOP_W    = 4;
    localparam int LOAD_STALL = 1;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [31:0] in_instr  = 32'h0;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b0;

    logic               in_ready;
    logic               out_valid;
    logic [1:0]         out_optype;
    logic [2:0]         out_deref;
    logic [ALUOP_W-1:0] out_aluop;
    logic [SHAMT_W-1:0] out_shamt;
    logic [1:0]         out_pccfg;
    logic               out_ramwe;
    logic               out_regwe;
    logic [1:0]         out_regsrc;
    logic [REG_AW-1:0]  out_rs;
    logic [REG_AW-1:0]  out_rt;
    logic [REG_AW-1:0]  out_dst;
    logic               out_illegal;
    logic               hazard_stall;

    decode_ctrl_stage #(
        .REG_AW    (REG_AW),
        .SHAMT_W   (SHAMT_W),
        .ALUOP_W   (ALUOP_W),
        .LOAD_STALL(LOAD_STALL)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_optype  (out_optype),
        .out_deref   (out_deref),
        .out_aluop   (out_aluop),
        .out_shamt   (out_shamt),
        .out_pccfg   (out_pccfg),
        .out_ramwe   (out_ramwe),
        .out_regwe   (out_regwe),
        .out_regsrc  (out_regsrc),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_dst     (out_dst),
        .out_illegal (out_illegal),
        .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]         optype;
        logic [2:0]         deref;
        logic [ALUOP_W-1:0] aluop;
        logic [SHAMT_W-1:0] shamt;
        logic [1:0]         pccfg;
        logic               ramwe;
        logic               regwe;
        logic [1:0]         regsrc;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  dst;
        logic               illegal;
    } exp_t;

    exp_t obs;
    assign obs = {out_optype, out_deref, out_aluop, out_shamt, out_pccfg, out_ramwe,
                  out_regwe, out_regsrc, out_rs, out_rt, out_dst, out_illegal};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: the output register plus the cycle index of the last LOAD
    // hand-off and of the last flush; the stall window is derived from those.
    logic       m_valid;
    exp_t       m_bundle;
    logic       m_is_load;
    logic [4:0] m_ld_dst;
    int         cyc;
    int         ld_xfer_cyc;
    int         last_flush_cyc;

    task automatic model_reset();
        m_valid        = 1'b0;
        m_bundle       = '0;
        m_is_load      = 1'b0;
        m_ld_dst       = '0;
        ld_xfer_cyc    = -1000;
        last_flush_cyc = -2000;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t b;
        int op, fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        b  = '0;
        if (op == 0 && fn <= 17) begin
            b.rs    = ins[25:21];
            b.shamt = ins[10:6];
            b.deref = 3'b010;
            if (fn <= 15) begin
                b.aluop = 4'(fn);
                b.deref = 3'b011;
                b.regwe = 1'b1;
                b.rt    = ins[20:16];
                b.dst   = ins[15:11];
            end else begin
                b.pccfg = 2'd2;
                if (fn == 17) begin
                    b.regwe  = 1'b1;
                    b.regsrc = 2'd2;
                    b.dst    = ins[15:11];
                end
            end
        end else if (op >= 1 && op <= 15) begin
            b.optype = 2'd1; b.aluop = 4'(op); b.deref = 3'b010;
            b.regwe  = 1'b1; b.rs = ins[25:21]; b.dst = ins[20:16];
        end else if (op >= 16 && op <= 19) begin
            b.optype = 2'd1; b.aluop = 4'(12 + op - 16); b.deref = 3'b110;
            b.pccfg  = 2'd1; b.rs = ins[25:21]; b.rt = ins[20:16];
        end else if (op == 32) begin
            b.optype = 2'd1; b.deref = 3'b010; b.regwe = 1'b1; b.regsrc = 2'd1;
            b.rs     = ins[25:21]; b.dst = ins[20:16];
        end else if (op == 33) begin
            b.optype = 2'd1; b.deref = 3'b010; b.ramwe = 1'b1;
            b.rs     = ins[25:21]; b.rt = ins[20:16];
        end else if (op == 48) begin
            b.optype = 2'd2; b.pccfg = 2'd2;
        end else if (op == 49) begin
            b.optype = 2'd2; b.pccfg = 2'd2; b.regwe = 1'b1; b.regsrc = 2'd2; b.dst = 5'h1F;
        end else begin
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    function automatic logic src_hot(input logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        if (m_valid && m_is_load && s == m_bundle.dst) return 1'b1;
        if (cyc > ld_xfer_cyc && (cyc - ld_xfer_cyc) <= LOAD_STALL &&
            last_flush_cyc < ld_xfer_cyc && s == m_ld_dst) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
        exp_t d;
        logic haz, exp_ready, exp_hs;
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        flush     = fl;
        out_ready = rdy;
        #1;
        d         = ref_decode(ins);
        haz       = src_hot(d.rs) || src_hot(d.rt);
        exp_ready = !fl && !haz && (!m_valid || rdy);
        exp_hs    = haz && v && !fl;
        check("out_valid", out_valid, m_valid);
        if (m_valid) check("bundle", obs, m_bundle);
        check("in_ready", in_ready, exp_ready);
        check("hazard_stall", hazard_stall, exp_hs);
        if (m_valid && rdy && m_is_load) begin
            ld_xfer_cyc = cyc;
            m_ld_dst    = m_bundle.dst;
        end
        if (fl) begin
            last_flush_cyc = cyc;
            m_valid        = 1'b0;
        end else if (v && exp_ready) begin
            m_valid   = 1'b1;
            m_bundle  = d;
            m_is_load = (ins[31:26] == 6'h20);
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        cyc++;
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_bundle", obs, 0);
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        logic [5:0] fn;
        case ($urandom_range(0, 9))
            0, 1:    op = 6'h00;
            2:       op = 6'($urandom_range(1, 15));
            3:       op = 6'($urandom_range(16, 19));
            4, 5:    op = 6'h20;
            6:       op = 6'h21;
            7:       op = 6'h30;
            8:       op = 6'h31;
            default: op = 6'($urandom);
        endcase
        fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 17));
        return mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom), fn);
    endfunction

    initial begin
        logic [31:0] dep;
        cyc = 0;
        model_reset();

        // Reset with garbage on the inputs.
        #1 rst_n = 1'b0;
        in_valid = 1'b1; in_instr = 32'hDEAD_BEEF; flush = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_bundle", obs, 0);
        @(negedge clk);
        in_valid = 1'b0; in_instr = 32'h0; flush = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_hazard", hazard_stall, 0);

        // Streaming R-add then BEQ.
        step(1, mk(6'h00, 1, 2, 3, 0, 6'h00), 0, 1);
        step(1, mk(6'h10, 4, 5, 0, 0, 6'h00), 0, 1);
        check("stream_ready", in_ready, 1);
        check("radd_optype", out_optype, 0);
        check("radd_deref", out_deref, 3'b011);
        check("radd_regwe", out_regwe, 1);
        check("radd_dst", out_dst, 3);
        step(0, 32'h0, 0, 1);
        check("beq_valid", out_valid, 1);
        check("beq_deref", out_deref, 3'b110);
        check("beq_aluop", out_aluop, 4'hC);
        check("beq_pccfg", out_pccfg, 1);
        check("beq_regwe", out_regwe, 0);

        // Load-use: stalled while LOAD is held, then for the counter window.
        dep = mk(6'h05, 7, 0, 9, 0, 0);
        step(1, mk(6'h20, 1, 7, 0, 0, 0), 0, 1);
        step(1, dep, 0, 1);
        check("lu_stall_held", hazard_stall, 1);
        check("lu_ready_held", in_ready, 0);
        step(1, dep, 0, 1);
        check("lu_stall_cnt", hazard_stall, 1);
        check("lu_ready_cnt", in_ready, 0);
        step(1, dep, 0, 1);
        check("lu_accept", in_ready, 1);
        step(1, mk(6'h20, 1, 7, 0, 0, 0), 0, 1);
        step(1, mk(6'h05, 0, 0, 9, 0, 0), 0, 1);
        check("lu_rs0_ready", in_ready, 1);
        check("lu_rs0_stall", hazard_stall, 0);

        // Backpressure with a JAL in the output register.
        step(1, mk(6'h31, 0, 0, 0, 0, 0), 0, 1);
        for (int k = 0; k < 4; k++) begin
            step(1, mk(6'h00, 1, 2, 3, 0, 6'h00), 0, 0);
            check("bp_dst", out_dst, 5'h1F);
            check("bp_regsrc", out_regsrc, 2);
            check("bp_ready", in_ready, 0);
        end
        step(1, mk(6'h00, 1, 2, 3, 0, 6'h00), 0, 1);
        check("bp_drain_ready", in_ready, 1);
        step(0, 32'h0, 0, 1);
        check("bp_next_dst", out_dst, 3);

        // Illegal opcode.
        step(1, mk(6'h3F, 1, 2, 3, 4, 5), 0, 1);
        step(0, 32'h0, 0, 1);
        check("ill_valid", out_valid, 1);
        check("ill_flag", out_illegal, 1);
        check("ill_regwe", out_regwe, 0);
        check("ill_ramwe", out_ramwe, 0);
        check("ill_pccfg", out_pccfg, 0);

        // Flush during a held LOAD with a dependent instruction waiting.
        dep = mk(6'h05, 9, 0, 4, 0, 0);
        step(1, mk(6'h20, 1, 9, 0, 0, 0), 0, 0);
        step(1, dep, 0, 0);
        check("fl_stall", hazard_stall, 1);
        step(1, dep, 1, 0);
        check("fl_hs_masked", hazard_stall, 0);
        check("fl_ready_masked", in_ready, 0);
        step(1, dep, 0, 1);
        check("fl_valid", out_valid, 0);
        check("fl_hs", hazard_stall, 0);
        check("fl_accept", in_ready, 1);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 1600; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0);
            if (i == 800) mid_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered, parametrised decode/control stage for the pipelined core, between fetch and execute. Each accepted 32-bit instruction is decoded into the control bundle (operation type, operand dereference, ALU op, shift amount, PC mode, RAM/register write enables, writeback source) plus register addresses. The result is held in an output register under a valid/ready handshake. The block stalls dependent instructions after a LOAD and supports a synchronous pipeline flush.

## Interface
- REG_AW, 5: register address width; JAL destination is all-ones.
- SHAMT_W, 5: shift-amount width.
- ALUOP_W, 4: ALU op width (≥4).
- LOAD_STALL, 1: cycles (0–7) a LOAD destination stays hazardous after it leaves the stage; 0 disables the hazard counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  fields, MSB-first: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], func[5:0]; address fields zero-extended or truncated to REG_AW.
- flush  in  1  synchronous kill of stage contents.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute accepts.
- out_optype  out  2  R=0, I=1, J=2.
- out_deref  out  3  bit2 DEST, bit1 OPA, bit0 OPB.
- out_aluop  out  ALUOP_W.
- out_shamt  out  SHAMT_W  R-type only, else 0.
- out_pccfg  out  2  NORMAL=0, STEP=1, REF=2.
- out_ramwe, out_regwe  out  1 each.
- out_regsrc  out  2  ALU=0, LOAD=1, PC=2.
- out_rs, out_rt, out_dst  out  REG_AW each.
- out_illegal  out  1  undecodable instruction.
- hazard_stall  out  1  in_ready low due to load-use only.

## Operation
Decode:
- **opcode 0x00, R-type.**
  - func 0x00–0x0F: arithmetic, aluop=func; deref OPA|OPB; regwe=1; dst=rd.
  - func 0x10: JR; deref OPA; pccfg REF.
  - func 0x11: JALR; deref OPA; pccfg REF; regwe=1; regsrc PC; dst=rd.
- **0x01–0x0F, I-arith.** aluop=opcode[3:0]; deref OPA; regwe=1; dst=rt.
- **0x10–0x13, branches.** aluop=0xC+(opcode−0x10); deref DEST|OPA; pccfg STEP.
- **0x20 LOAD.** aluop ADD(0); deref OPA; regwe=1; regsrc LOAD; dst=rt.
- **0x21 STORE.** aluop ADD; deref OPA; ramwe=1; reads rt.
- **0x30 J.** optype J; pccfg REF.
- **0x31 JAL.** optype J; pccfg REF; regwe=1; regsrc PC; dst=all-ones.
- **Anything else.** illegal=1, all enables 0, pccfg NORMAL, still emitted.

Unused fields are 0. Source use: rs for every non-J except illegal; rt for R-arith, branch, STORE.

Hazard:
- Hazard when an incoming used source ≠0 matches `ld_dst`, under either condition:
  - out register holds a valid LOAD with dst `ld_dst`; or
  - `ld_cnt`>0 and `ld_dst` is the last issued LOAD destination.
- `ld_cnt` loads LOAD_STALL when a LOAD transfers out (out_valid&out_ready), otherwise decrements to 0.
- A new LOAD transfer reloads `ld_cnt` and `ld_dst`.

## Timing
- Reset: out_valid=0, all out_* fields 0, `ld_cnt`=0, `ld_dst`=0. in_ready is 1 after reset.
- in_ready = !flush & !hazard & (!out_valid | out_ready). Combinational.
- in_valid & in_ready: the bundle appears on out_* the next cycle with out_valid=1. Latency 1, throughput 1/cycle.
- While out_valid & !out_ready, all out_* hold stable.
- hazard_stall = hazard & in_valid & !flush.
- flush: next cycle out_valid=0, `ld_cnt`=0, and no input is accepted that cycle. Flush wins over a simultaneous out transfer's counter load.
- Reset asserted mid-operation clears state immediately and discards any held bundle.

## Test plan
- **Reset.** Drive rst_n=0 with garbage on inputs → out_valid=0, all outputs 0, in_ready=1 after release.
- **Streaming.** Send R-add (func 0x00, rs=1, rt=2, rd=3) then BEQ (opcode 0x10, rs=4, rt=5) with out_ready=1 → consecutive cycles:
  - R-add: optype 0, deref 3'b011, regwe 1, dst 3.
  - BEQ: deref 3'b110, aluop 0xC, pccfg 1, regwe 0.
- **Load-use.** LOAD rt=7, LOAD_STALL=1, then I-arith rs=7 → hazard_stall=1, in_ready=0 for 2 cycles (LOAD held, then counter), accepted on 3rd. With rs=0 instead → no stall.
- **Backpressure.** out_ready=0 for 4 cycles with JAL queued → out_* stable, dst=5'h1F, regsrc 2, in_ready=0; drains 1 cycle after out_ready=1.
- **Illegal.** Send opcode 0x3F → illegal=1, regwe=ramwe=0, pccfg 0, still out_valid=1.
- **Flush.** Flush during a held LOAD and stall → next cycle out_valid=0, hazard_stall=0, dependent instruction accepted.
